// File: rtl/duck_round_ctrl_if.sv
// Signal bundle between the round controller and the gun/scope path, duck movers and display.
// The controller connects through the master modport.
interface duck_round_ctrl_if #(
   parameter int N_DUCKS      = 2,
   parameter int BULLETS      = 3,
   parameter int LIVES        = 4,
   parameter int SCORE_DIGITS = 2
);
   localparam int LW = $clog2(LIVES + 1);
   localparam int BW = $clog2(BULLETS + 1);

   logic                      frame_tick;
   logic                      start_btn;
   logic                      trigger;
   logic [9:0]                scope_x;
   logic [9:0]                scope_y;
   logic [10*N_DUCKS-1:0]     duck_x;
   logic [10*N_DUCKS-1:0]     duck_y;
   logic [N_DUCKS-1:0]        spawn;
   logic [N_DUCKS-1:0]        duck_active;
   logic                      hit_pulse;
   logic [4*SCORE_DIGITS-1:0] score_bcd;
   logic [LW-1:0]             lives;
   logic [BW-1:0]             bullets;
   logic                      is_home;
   logic                      is_gameover;

   modport master (
      input  frame_tick, start_btn, trigger, scope_x, scope_y, duck_x, duck_y,
      output spawn, duck_active, hit_pulse, score_bcd, lives, bullets, is_home, is_gameover
   );

   modport slave (
      output frame_tick, start_btn, trigger, scope_x, scope_y, duck_x, duck_y,
      input  spawn, duck_active, hit_pulse, score_bcd, lives, bullets, is_home, is_gameover
   );
endinterface

// File: rtl/duck_round_ctrl.sv
// Game-round controller for N_DUCKS targets: spawning, shot/hit resolution, escapes,
// BCD score, lives and bullets, sequencing HOME -> SPAWN -> PLAY -> ROUND_END / GAMEOVER.
module duck_round_ctrl #(
   parameter int N_DUCKS       = 2,
   parameter int BULLETS       = 3,
   parameter int LIVES         = 4,
   parameter int SCORE_DIGITS  = 2,
   parameter int DUCK_W        = 32,
   parameter int DUCK_H        = 32,
   parameter int ESCAPE_FRAMES = 300,
   parameter int GAP_FRAMES    = 60
) (
   input  logic              Clk,
   input  logic              rst_n,
   duck_round_ctrl_if.master bus
);
   localparam int LW   = $clog2(LIVES + 1);
   localparam int BW   = $clog2(BULLETS + 1);
   localparam int SW   = 4 * SCORE_DIGITS;
   localparam int FMAX = (ESCAPE_FRAMES > GAP_FRAMES) ? ESCAPE_FRAMES : GAP_FRAMES;
   localparam int FW   = $clog2(FMAX + 1);

   typedef enum logic [2:0] {
      S_HOME, S_SPAWN, S_PLAY, S_ROUND_END, S_GAMEOVER
   } state_e;

   state_e             state_q, state_d;
   logic [SW-1:0]      score_q, score_d;
   logic [LW-1:0]      lives_q, lives_d;
   logic [BW-1:0]      bullets_q, bullets_d;
   logic [N_DUCKS-1:0] active_q, active_d;
   logic               hit_q, hit_d;
   logic [FW-1:0]      frame_q, frame_d;
   logic               trig_q, trig_d;

   logic [10:0]        sx, sy;
   logic [N_DUCKS-1:0] in_box, kill, survivors;
   logic               shot, escape;
   logic [3:0]         esc_cnt;
   logic [LW-1:0]      lives_left;

   // Increment with ripple carry; an all-nines score holds instead of wrapping.
   function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] s);
      logic [SW-1:0] r;
      logic          carry;
      logic          sat;
      r     = s;
      carry = 1'b1;
      sat   = 1'b1;
      for (int i = 0; i < SCORE_DIGITS; i++) begin
         if (s[4*i +: 4] != 4'd9) sat = 1'b0;
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return sat ? s : r;
   endfunction

   function automatic logic [3:0] popcount(input logic [N_DUCKS-1:0] v);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int i = 0; i < N_DUCKS; i++) cnt = cnt + 4'(v[i]);
      return cnt;
   endfunction

   // 11-bit compares so a duck near the right/bottom edge never wraps its box.
   assign sx = {1'b0, bus.scope_x};
   assign sy = {1'b0, bus.scope_y};
   for (genvar i = 0; i < N_DUCKS; i++) begin : g_box
      logic [10:0] x0, y0;
      assign x0        = {1'b0, bus.duck_x[10*i +: 10]};
      assign y0        = {1'b0, bus.duck_y[10*i +: 10]};
      assign in_box[i] = active_q[i] && (sx >= x0) && (sx < x0 + 11'(DUCK_W))
                                     && (sy >= y0) && (sy < y0 + 11'(DUCK_H));
   end

   assign shot       = bus.trigger && !trig_q && (bullets_q != '0);
   // Isolate the lowest set bit: only the lowest-index duck under the scope dies.
   assign kill       = shot ? (in_box & (~in_box + N_DUCKS'(1))) : '0;
   assign survivors  = active_q & ~kill;
   assign escape     = (frame_q == FW'(ESCAPE_FRAMES)) || ((bullets_q == '0) && (|active_q));
   assign esc_cnt    = popcount(survivors);
   assign lives_left = (32'(lives_q) <= 32'(esc_cnt)) ? '0 : lives_q - LW'(esc_cnt);

   // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      score_d   = score_q;
      lives_d   = lives_q;
      bullets_d = bullets_q;
      active_d  = active_q;
      hit_d     = 1'b0;
      frame_d   = frame_q;
      trig_d    = bus.trigger;

      case (state_q)
         S_HOME: begin
            if (bus.start_btn) state_d = S_SPAWN;
         end
         S_SPAWN: begin
            active_d  = '1;
            bullets_d = BW'(BULLETS);
            frame_d   = '0;
            state_d   = S_PLAY;
         end
         S_PLAY: begin
            if (shot) bullets_d = bullets_q - BW'(1);
            if (|kill) begin
               hit_d   = 1'b1;
               score_d = bcd_inc(score_q);
            end
            active_d = survivors;
            if (bus.frame_tick) frame_d = frame_q + FW'(1);
            if (escape) begin
               active_d = '0;
               lives_d  = lives_left;
            end
            if (active_d == '0) begin
               state_d = (lives_d == '0) ? S_GAMEOVER : S_ROUND_END;
               frame_d = '0;
            end
         end
         S_ROUND_END: begin
            if (frame_q == FW'(GAP_FRAMES)) state_d = S_SPAWN;
            else if (bus.frame_tick)        frame_d = frame_q + FW'(1);
         end
         S_GAMEOVER: begin
            if (bus.start_btn) begin
               state_d = S_HOME;
               score_d = '0;
               lives_d = LW'(LIVES);
            end
         end
         default: state_d = S_HOME;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_HOME;
         score_q   <= '0;
         lives_q   <= LW'(LIVES);
         bullets_q <= BW'(BULLETS);
         active_q  <= '0;
         hit_q     <= 1'b0;
         frame_q   <= '0;
         trig_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         score_q   <= score_d;
         lives_q   <= lives_d;
         bullets_q <= bullets_d;
         active_q  <= active_d;
         hit_q     <= hit_d;
         frame_q   <= frame_d;
         trig_q    <= trig_d;
      end
   end

   assign bus.spawn       = {N_DUCKS{state_q == S_SPAWN}};
   assign bus.duck_active = active_q;
   assign bus.hit_pulse   = hit_q;
   assign bus.score_bcd   = score_q;
   assign bus.lives       = lives_q;
   assign bus.bullets     = bullets_q;
   assign bus.is_home     = (state_q == S_HOME);
   assign bus.is_gameover = (state_q == S_GAMEOVER);
endmodule

// File: tb/tb_duck_round_ctrl.sv
// Bench for duck_round_ctrl: directed scenarios plus random play on two instances
// (LIVES=4 and LIVES=1) sharing one stimulus, judged against a behavioural game model.
module tb_duck_round_ctrl;
   localparam int BULLETS = 3;
   localparam int ESCAPE  = 300;
   localparam int GAP     = 60;
   localparam int DW      = 32;
   localparam int DH      = 32;

   typedef enum int {P_HOME, P_SPAWN, P_PLAY, P_GAP, P_OVER} phase_e;
   typedef struct {
      phase_e     phase;
      int         score;
      int         lives;
      int         bullets;
      logic [1:0] active;
      logic       hit;
      int         frames;
      logic       trig_prev;
   } mdl_t;

   localparam logic [19:0] RST0 = {2'b00, 2'b00, 1'b0, 8'h00, 3'd4, 2'd3, 1'b1, 1'b0};
   localparam logic [19:0] RST1 = {2'b00, 2'b00, 1'b0, 8'h00, 3'd1, 2'd3, 1'b1, 1'b0};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_tick = 1'b0;
   logic       start_btn = 1'b0;
   logic       trigger = 1'b0;
   logic [9:0] scope_x = '0;
   logic [9:0] scope_y = '0;
   logic [19:0] duck_x = '0;
   logic [19:0] duck_y = '0;
   int         checks = 0;
   int         errors = 0;
   mdl_t       m0, m1;
   logic [19:0] dut0_vec, dut1_vec;

   always #10 clk = ~clk;

   duck_round_ctrl_if #(.LIVES(4)) if0 ();
   duck_round_ctrl_if #(.LIVES(1)) if1 ();

   assign if0.frame_tick = frame_tick;  assign if1.frame_tick = frame_tick;
   assign if0.start_btn  = start_btn;   assign if1.start_btn  = start_btn;
   assign if0.trigger    = trigger;     assign if1.trigger    = trigger;
   assign if0.scope_x    = scope_x;     assign if1.scope_x    = scope_x;
   assign if0.scope_y    = scope_y;     assign if1.scope_y    = scope_y;
   assign if0.duck_x     = duck_x;      assign if1.duck_x     = duck_x;
   assign if0.duck_y     = duck_y;      assign if1.duck_y     = duck_y;

   duck_round_ctrl u_dut0 (.Clk(clk), .rst_n(rst_n), .bus(if0.master));
   duck_round_ctrl #(.LIVES(1)) u_dut1 (.Clk(clk), .rst_n(rst_n), .bus(if1.master));

   assign dut0_vec = {if0.spawn, if0.duck_active, if0.hit_pulse, if0.score_bcd,
                      if0.lives, if0.bullets, if0.is_home, if0.is_gameover};
   assign dut1_vec = {if1.spawn, if1.duck_active, if1.hit_pulse, if1.score_bcd,
                      {2'b00, if1.lives}, if1.bullets, if1.is_home, if1.is_gameover};

   // ---------------- behavioural game model ----------------
   function automatic mdl_t model_reset(int l0);
      mdl_t m;
      m.phase = P_HOME;  m.score = 0;   m.lives = l0;  m.bullets = BULLETS;
      m.active = 2'b00;  m.hit = 1'b0;  m.frames = 0;  m.trig_prev = 1'b0;
      return m;
   endfunction

   function automatic bit on_duck(int i);
      int dx, dy, sx, sy;
      dx = int'(duck_x[10*i +: 10]);  dy = int'(duck_y[10*i +: 10]);
      sx = int'(scope_x);             sy = int'(scope_y);
      return (sx >= dx) && (sx < dx + DW) && (sy >= dy) && (sy < dy + DH);
   endfunction

   function automatic mdl_t model_next(mdl_t c, int l0);
      mdl_t n;
      int   kill;
      bit   out_of_time, out_of_ammo;
      n = c;
      n.hit = 1'b0;
      n.trig_prev = trigger;
      kill = -1;
      case (c.phase)
         P_HOME:  if (start_btn) n.phase = P_SPAWN;
         P_SPAWN: begin
            n.active = 2'b11;  n.bullets = BULLETS;  n.frames = 0;  n.phase = P_PLAY;
         end
         P_PLAY: begin
            out_of_time = (c.frames == ESCAPE);
            out_of_ammo = (c.bullets == 0) && (c.active != 2'b00);
            if (trigger && !c.trig_prev && c.bullets > 0) begin
               n.bullets = c.bullets - 1;
               for (int i = 0; i < 2; i++)
                  if (kill < 0 && c.active[i] && on_duck(i)) kill = i;
            end
            if (kill >= 0) begin
               n.active[kill] = 1'b0;
               n.hit = 1'b1;
               n.score = (c.score < 99) ? c.score + 1 : 99;
            end
            if (frame_tick) n.frames = c.frames + 1;
            if (out_of_time || out_of_ammo) begin
               n.lives  = c.lives - $countones(n.active);
               if (n.lives < 0) n.lives = 0;
               n.active = 2'b00;
            end
            if (n.active == 2'b00) begin
               n.phase  = (n.lives == 0) ? P_OVER : P_GAP;
               n.frames = 0;
            end
         end
         P_GAP: begin
            if (c.frames == GAP) n.phase = P_SPAWN;
            else if (frame_tick) n.frames = c.frames + 1;
         end
         P_OVER: if (start_btn) begin
            n.phase = P_HOME;  n.score = 0;  n.lives = l0;
         end
         default: n.phase = P_HOME;
      endcase
      return n;
   endfunction

   function automatic logic [19:0] exp_vec(mdl_t m);
      logic sp;
      sp = (m.phase == P_SPAWN);
      return {sp, sp, m.active, m.hit, 4'(m.score / 10), 4'(m.score % 10),
              3'(m.lives), 2'(m.bullets), m.phase == P_HOME, m.phase == P_OVER};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0 <= model_reset(4);
         m1 <= model_reset(1);
      end else begin
         m0 <= model_next(m0, 4);
         m1 <= model_next(m1, 1);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cycle();
      @(negedge clk);
   endtask

   task automatic fire(input logic [9:0] x, input logic [9:0] y);
      scope_x = x;  scope_y = y;  trigger = 1'b1;
      cycle();
   endtask

   task automatic let_go();
      trigger = 1'b0;
      cycle();
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         frame_tick = 1'b1;  cycle();
         frame_tick = 1'b0;  cycle();
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (2) cycle();
      checks++; if (dut0_vec !== RST0) begin errors++; $display("FAIL reset_inst0 got %h want %h", dut0_vec, RST0); end
      checks++; if (dut1_vec !== RST1) begin errors++; $display("FAIL reset_inst1 got %h want %h", dut1_vec, RST1); end
      rst_n = 1'b1;
      cycle();
      checks++; if (dut0_vec !== exp_vec(m0)) begin errors++; $display("FAIL idle_home got %h want %h", dut0_vec, exp_vec(m0)); end
   endtask

   task automatic test_spawn();
      start_btn = 1'b1;
      cycle();
      start_btn = 1'b0;
      checks++; if (if0.spawn !== 2'b11 || if0.duck_active !== 2'b00) begin errors++;
         $display("FAIL spawn_pulse got spawn=%b active=%b want 11/00", if0.spawn, if0.duck_active); end
      cycle();
      checks++; if (dut0_vec !== {2'b00, 2'b11, 1'b0, 8'h00, 3'd4, 2'd3, 1'b0, 1'b0}) begin errors++;
         $display("FAIL play_entry got %h", dut0_vec); end
      checks++; if (dut1_vec !== exp_vec(m1)) begin errors++; $display("FAIL play_entry_inst1 got %h want %h", dut1_vec, exp_vec(m1)); end
   endtask

   task automatic test_escape();
      duck_x = {10'd300, 10'd100};
      duck_y = {10'd300, 10'd100};
      for (int s = 0; s < 3; s++) begin
         fire(10'd600, 10'd600);
         checks++; if (if0.bullets !== 2'(2 - s) || if0.hit_pulse !== 1'b0 || if0.duck_active !== 2'b11) begin errors++;
            $display("FAIL miss_%0d got bullets=%0d hit=%b active=%b", s, if0.bullets, if0.hit_pulse, if0.duck_active); end
         let_go();
      end
      checks++; if (if0.duck_active !== 2'b00 || if0.lives !== 3'd2 || if0.is_gameover !== 1'b0 || if0.is_home !== 1'b0) begin errors++;
         $display("FAIL escape got active=%b lives=%0d", if0.duck_active, if0.lives); end
      checks++; if (if1.lives !== 1'b0 || if1.is_gameover !== 1'b1) begin errors++;
         $display("FAIL lives_saturate got lives=%0d over=%b want 0/1", if1.lives, if1.is_gameover); end
      frames(GAP - 1);
      checks++; if (if0.spawn !== 2'b00) begin errors++; $display("FAIL gap_early_spawn got %b want 00", if0.spawn); end
      frames(1);
      checks++; if (if0.spawn !== 2'b11) begin errors++; $display("FAIL gap_spawn got %b want 11", if0.spawn); end
      cycle();
      checks++; if (dut0_vec !== exp_vec(m0)) begin errors++; $display("FAIL respawn got %h want %h", dut0_vec, exp_vec(m0)); end
      checks++; if (dut1_vec !== exp_vec(m1)) begin errors++; $display("FAIL over_hold got %h want %h", dut1_vec, exp_vec(m1)); end
   endtask

   task automatic test_overlap_hit_miss();
      duck_x = {10'd100, 10'd100};
      duck_y = {10'd100, 10'd100};
      fire(10'd110, 10'd120);
      checks++; if (if0.hit_pulse !== 1'b1 || if0.duck_active !== 2'b10 || if0.bullets !== 2'd2 || if0.score_bcd !== 8'h01) begin errors++;
         $display("FAIL overlap_kill got hit=%b active=%b bullets=%0d score=%h", if0.hit_pulse, if0.duck_active, if0.bullets, if0.score_bcd); end
      let_go();
      checks++; if (if0.hit_pulse !== 1'b0) begin errors++; $display("FAIL hit_width got %b want 0", if0.hit_pulse); end
      fire(10'd132, 10'd100);
      checks++; if (if0.hit_pulse !== 1'b0 || if0.bullets !== 2'd1 || if0.duck_active !== 2'b10) begin errors++;
         $display("FAIL edge_miss got hit=%b bullets=%0d active=%b", if0.hit_pulse, if0.bullets, if0.duck_active); end
      let_go();
      fire(10'd100, 10'd131);
      checks++; if (if0.hit_pulse !== 1'b1 || if0.duck_active !== 2'b00 || if0.score_bcd !== 8'h02) begin errors++;
         $display("FAIL last_bullet_kill got hit=%b active=%b score=%h", if0.hit_pulse, if0.duck_active, if0.score_bcd); end
      let_go();
      checks++; if (if0.lives !== 3'd2 || if0.is_gameover !== 1'b0) begin errors++;
         $display("FAIL no_escape_after_clear got lives=%0d over=%b", if0.lives, if0.is_gameover); end
      frames(GAP);
      cycle();
      checks++; if (dut0_vec !== exp_vec(m0)) begin errors++; $display("FAIL round3_start got %h want %h", dut0_vec, exp_vec(m0)); end
   endtask

   task automatic test_timeout();
      frames(ESCAPE - 1);
      checks++; if (if0.duck_active !== 2'b11) begin errors++; $display("FAIL early_escape got %b want 11", if0.duck_active); end
      frames(1);
      checks++; if (if0.duck_active !== 2'b00 || if0.lives !== 3'd0 || if0.is_gameover !== 1'b1) begin errors++;
         $display("FAIL timeout got active=%b lives=%0d over=%b", if0.duck_active, if0.lives, if0.is_gameover); end
      start_btn = 1'b1;
      cycle();
      start_btn = 1'b0;
      checks++; if (dut0_vec !== RST0) begin errors++; $display("FAIL back_home got %h want %h", dut0_vec, RST0); end
      checks++; if (dut1_vec !== exp_vec(m1)) begin errors++; $display("FAIL back_home_inst1 got %h want %h", dut1_vec, exp_vec(m1)); end
   endtask

   task automatic test_score();
      logic [7:0] want;
      int hits;
      start_btn = 1'b1;  cycle();
      start_btn = 1'b0;  cycle();
      for (int r = 0; r < 50; r++) begin
         duck_x = {10'($urandom_range(0, 980)), 10'($urandom_range(0, 980))};
         duck_y = {10'($urandom_range(0, 900)), 10'($urandom_range(0, 900))};
         for (int d = 0; d < 2; d++) begin
            fire(10'(int'(duck_x[10*d +: 10]) + $urandom_range(0, DW - 1)),
                 10'(int'(duck_y[10*d +: 10]) + $urandom_range(0, DH - 1)));
            hits = 2 * r + d + 1;
            checks++; if (dut0_vec !== exp_vec(m0)) begin errors++; $display("FAIL score_run0 hit %0d got %h want %h", hits, dut0_vec, exp_vec(m0)); end
            checks++; if (dut1_vec !== exp_vec(m1)) begin errors++; $display("FAIL score_run1 hit %0d got %h want %h", hits, dut1_vec, exp_vec(m1)); end
            if (hits == 9 || hits == 10 || hits >= 99) begin
               want = (hits == 9) ? 8'h09 : (hits == 10) ? 8'h10 : 8'h99;
               checks++; if (if0.score_bcd !== want || if0.hit_pulse !== 1'b1) begin errors++;
                  $display("FAIL score_bcd hit %0d got %h want %h", hits, if0.score_bcd, want); end
            end
            let_go();
         end
         frames(GAP);
         cycle();
      end
   endtask

   task automatic test_reset_mid_play();
      fire(10'd1023, 10'd1023);
      let_go();
      fire(10'd1023, 10'd1023);
      checks++; if (if0.bullets !== 2'd1) begin errors++; $display("FAIL pre_reset_bullets got %0d want 1", if0.bullets); end
      #5 rst_n = 1'b0;
      #1;
      checks++; if (dut0_vec !== RST0) begin errors++; $display("FAIL async_reset0 got %h want %h", dut0_vec, RST0); end
      checks++; if (dut1_vec !== RST1) begin errors++; $display("FAIL async_reset1 got %h want %h", dut1_vec, RST1); end
      cycle();
      rst_n = 1'b1;
      cycle();
      start_btn = 1'b1;  cycle();
      start_btn = 1'b0;  cycle();
      repeat (3) cycle();
      checks++; if (if0.bullets !== 2'd3 || if0.duck_active !== 2'b11) begin errors++;
         $display("FAIL held_trigger got bullets=%0d active=%b want 3/11", if0.bullets, if0.duck_active); end
      trigger = 1'b0;  cycle();
      trigger = 1'b1;  cycle();
      checks++; if (if0.bullets !== 2'd2) begin errors++; $display("FAIL fresh_edge got bullets=%0d want 2", if0.bullets); end
      checks++; if (dut1_vec !== exp_vec(m1)) begin errors++; $display("FAIL fresh_edge_inst1 got %h want %h", dut1_vec, exp_vec(m1)); end
      let_go();
   endtask

   task automatic test_random();
      int k;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 99) == 0) begin
            duck_x = {10'($urandom_range(0, 980)), 10'($urandom_range(0, 980))};
            duck_y = {10'($urandom_range(0, 980)), 10'($urandom_range(0, 980))};
         end
         k = int'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 0) begin
            scope_x = 10'(int'(duck_x[10*k +: 10]) + $urandom_range(0, 40));
            scope_y = 10'(int'(duck_y[10*k +: 10]) + $urandom_range(0, 40));
         end else begin
            scope_x = 10'($urandom_range(0, 1023));
            scope_y = 10'($urandom_range(0, 1023));
         end
         trigger    = ($urandom_range(0, 3) == 0);
         frame_tick = ($urandom_range(0, 2) == 0);
         start_btn  = ($urandom_range(0, 39) == 0);
         cycle();
         checks++; if (dut0_vec !== exp_vec(m0)) begin errors++; $display("FAIL random0 cycle %0d got %h want %h", c, dut0_vec, exp_vec(m0)); end
         checks++; if (dut1_vec !== exp_vec(m1)) begin errors++; $display("FAIL random1 cycle %0d got %h want %h", c, dut1_vec, exp_vec(m1)); end
      end
      trigger = 1'b0;  frame_tick = 1'b0;  start_btn = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_spawn();
      test_escape();
      test_overlap_hit_miss();
      test_timeout();
      test_score();
      test_reset_mid_play();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/duck_round_ctrl.md
Name: duck_round_ctrl

Overview:
Parametrised game-round controller that generalises the fixed two-duck score/lives/bullet logic to N_DUCKS targets per round. It sits between the light-gun/scope path and the duck movers and colour mapper: it decides when ducks spawn, detects shots and hits, and counts escapes. It also tracks BCD score, lives and bullets, and sequences home → play → round gap → game over. All state advances on Clk; game timing is counted in frame_tick pulses.

Parameters:
N_DUCKS, 2, targets per round (1..8)
BULLETS, 3, shots loaded per round (1..15)
LIVES, 4, starting lives (1..15)
SCORE_DIGITS, 2, BCD score digits (1..4)
DUCK_W, 32, hit box width in pixels
DUCK_H, 32, hit box height in pixels
ESCAPE_FRAMES, 300, frames a round lasts before surviving ducks escape
GAP_FRAMES, 60, frames spent in ROUND_END before the next spawn

Ports:
Clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  single-Clk pulse once per frame, already synchronised
start_btn  in  1  level, synchronised; leaves home/game-over screens
trigger  in  1  debounced light-gun trigger, level
scope_x  in  10  scope centre X
scope_y  in  10  scope centre Y
duck_x  in  10*N_DUCKS  packed duck top-left X, duck i at [10i+9:10i]
duck_y  in  10*N_DUCKS  packed duck top-left Y
spawn  out  N_DUCKS  one-Clk pulse per duck asking its mover to respawn
duck_active  out  N_DUCKS  duck alive and drawable
hit_pulse  out  1  one-Clk pulse on a successful hit
score_bcd  out  4*SCORE_DIGITS  BCD score, digit 0 in the LSBs
lives  out  $clog2(LIVES+1)  remaining lives
bullets  out  $clog2(BULLETS+1)  remaining bullets
is_home  out  1  HOME state
is_gameover  out  1  GAMEOVER state

Behaviour:
- Reset values: state HOME; score 0; lives=LIVES; bullets=BULLETS; duck_active=0; spawn=0; hit_pulse=0; frame counter 0; trigger edge register 0.
- States: HOME, SPAWN, PLAY, ROUND_END, GAMEOVER.
- HOME: is_home=1. start_btn=1 → SPAWN. On entry, score=0, lives=LIVES.
- SPAWN (1 cycle): spawn=all ones for this cycle; duck_active=all ones next cycle; bullets=BULLETS; frame counter=0; → PLAY.
- PLAY:
  - Shot: a rising edge of trigger (registered copy 0, trigger 1) with bullets>0 decrements bullets the next cycle. Edges with bullets=0 are ignored.
  - Hit test, same cycle as the shot: duck i is hit if duck_active[i] and duck_x[i] ≤ scope_x < duck_x[i]+DUCK_W and duck_y[i] ≤ scope_y < duck_y[i]+DUCK_H. Use 11-bit sums; no wrap.
  - At most one kill per shot: the lowest-index duck that is hit. It clears duck_active[i], raises hit_pulse for 1 cycle and increments score by 1.
  - Score: BCD ripple carry; saturates at all nines.
  - frame_tick increments the frame counter. When the counter reaches ESCAPE_FRAMES, or when bullets=0 with any duck active, all active ducks escape.
  - Escape: duck_active cleared; lives decreases by popcount of the escaping ducks, saturating at 0.
  - Shot and escape in the same cycle: the hit is resolved first, so the killed duck does not count as escaped.
  - Last bullet: if the last bullet kills the last active duck, there is no escape. If the last bullet misses, the escape happens the next cycle.
  - duck_active becomes 0 → lives=0 ? GAMEOVER : ROUND_END.
- ROUND_END: frame counter restarts at 0 on entry and counts frame_ticks. Reaching GAP_FRAMES → SPAWN. Triggers are ignored.
- GAMEOVER: is_gameover=1; score and lives hold. start_btn=1 → HOME.
- The trigger edge register updates in every state, so a trigger held across a state change never fires a shot.
- rst_n asserted at any time, including mid-round, returns all outputs to reset values asynchronously. Release is synchronous to Clk; the next edge is the first active one.

Test Plan:
- Reset, then start_btn=1 → 1-cycle spawn=2'b11, then duck_active=2'b11, bullets=3, lives=4, score=00.
- duck0 at (100,100), scope (110,120), trigger rise → hit_pulse 1 cycle, duck_active=2'b10, bullets=2, score_bcd=8'h01; scope (132,100) on the next shot → miss, bullets=1.
- Both ducks overlapping the scope, one trigger → only duck0 killed; 3 bullets all miss → both ducks escape, lives 4→2, state ROUND_END, then SPAWN after 60 frame_ticks.
- No shots for 300 frame_ticks with N_DUCKS=2, LIVES=1 → lives saturates at 0 (not wrapping), is_gameover=1; start_btn → is_home=1.
- Score 8'h99 plus a hit → stays 8'h99; score 8'h09 plus a hit → 8'h10.
- rst_n low mid-PLAY with bullets=1 and trigger held high → outputs at reset values; trigger still high after start → no shot until a fresh rising edge.
